lfsr_bank: RTL and testbench

- Bank of CHANNELS independent maximal-length Fibonacci LFSRs, each WIDTH bits wide, for the Monte-Carlo sample generators.
- Each channel can be seeded individually at run time.
- Leap-ahead is supported: STEPS shifts are applied per output transfer, so adjacent outputs are less correlated.
- Output is a valid/ready stream carrying all channels in one word. It feeds the coordinate/sample consumers in place of the single-channel generator.

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_bank_if.sv | 30 +++
 rtl/lfsr_channel.sv | 51 +++++
 rtl/lfsr_bank.sv | 89 ++++++++
 tb/tb_lfsr_bank.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: maximal-length tap masks, FSM state type and one-shift helper.
// Purely combinational content, no latency or flow control of its own.
package lfsr_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsr_state_t;

    // Polynomial tap t lives in bit t-1; entry W is a primitive degree-W polynomial.
    localparam logic [31:0] TAP_MASK [MIN_WIDTH:MAX_WIDTH] = '{
        32'h0000_0003, 32'h0000_0006, 32'h0000_000C, 32'h0000_0014,
        32'h0000_0030, 32'h0000_0060, 32'h0000_00B8, 32'h0000_0110,
        32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
        32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000,
        32'h0002_0400, 32'h0004_0023, 32'h0009_0000, 32'h0014_0000,
        32'h0030_0000, 32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
        32'h0200_0023, 32'h0400_0013, 32'h0900_0000, 32'h1400_0000,
        32'h2000_0029, 32'h4800_0000, 32'h8020_0003
    };

    function automatic logic [31:0] lfsr_step(input logic [31:0] state, input int width);
        logic [31:0] keep;
        logic        fb;
        fb   = ^(state & TAP_MASK[width]);
        keep = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return ((state << 1) | {31'd0, fb}) & keep;
    endfunction

endpackage

// File: rtl/lfsr_bank_if.sv
// Control, seed and output-stream signals of the LFSR bank.
// slave = generator side, master = controller/consumer side.
interface lfsr_bank_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      start;
    logic                      stop;
    logic                      seed_valid;
    logic                      seed_ready;
    logic [CW-1:0]             seed_chan;
    logic [WIDTH-1:0]          seed;
    logic                      seed_zero_fix;
    logic                      rnd_valid;
    logic                      rnd_ready;
    logic [CHANNELS*WIDTH-1:0] rnd;
    logic [31:0]               xfer_count;

    modport master (
        output start, stop, seed_valid, seed_chan, seed, rnd_ready,
        input  seed_ready, seed_zero_fix, rnd_valid, rnd, xfer_count
    );

    modport slave (
        input  start, stop, seed_valid, seed_chan, seed, rnd_ready,
        output seed_ready, seed_zero_fix, rnd_valid, rnd, xfer_count
    );
endinterface

// File: rtl/lfsr_channel.sv
// One Fibonacci LFSR register: seed load (zero replaced by 1) beats a STEPS-shift advance.
// Update lands one cycle after load/advance; the register holds whenever neither is asserted.
module lfsr_channel
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEPS = 1,
    parameter int INIT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_adv,
    output logic [WIDTH-1:0] o_state,
    output logic             o_zero_fix
);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] r_state;
    logic             r_zero_fix;
    logic [31:0]      w_walk;
    logic             w_seed_zero;

    assign w_seed_zero = (i_seed == '0);

    // All STEPS shifts are unrolled so a leap costs a single cycle.
    always_comb begin
        w_walk = 32'(r_state);
        for (int s = 0; s < STEPS; s++) begin
            w_walk = lfsr_step(w_walk, WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= INIT_V;
            r_zero_fix <= 1'b0;
        end else begin
            r_zero_fix <= i_load && w_seed_zero;
            if (i_load) begin
                r_state <= w_seed_zero ? WIDTH'(1) : i_seed;
            end else if (i_adv) begin
                r_state <= w_walk[WIDTH-1:0];
            end
        end
    end

    assign o_state    = r_state;
    assign o_zero_fix = r_zero_fix;
endmodule

// File: rtl/lfsr_bank.sv
// Bank of CHANNELS LFSRs streamed as one valid/ready word; 1-cycle handshake-to-rnd latency.
// rnd_valid && !rnd_ready freezes every channel and the transfer counter until accepted.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int STEPS    = 1
) (
    input  logic         clk,
    input  logic         rst,
    lfsr_bank_if.slave   bus
);
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("lfsr_bank: WIDTH must be in 2..32");
    end
    if (CHANNELS < 1 || longint'(CHANNELS) > ((longint'(1) << WIDTH) - longint'(1))) begin : g_bad_chan
        $error("lfsr_bank: CHANNELS must be in 1..2**WIDTH-1");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_bank: STEPS must be in 1..WIDTH");
    end

    lfsr_state_t               r_fsm;
    logic                      r_rnd_valid;
    logic [31:0]               r_xfer_count;
    logic                      w_fire;
    logic [CHANNELS-1:0]       w_load;
    logic [CHANNELS-1:0]       w_zero_fix;
    logic [CHANNELS*WIDTH-1:0] w_rnd;

    assign w_fire = r_rnd_valid && bus.rnd_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Out-of-range channel indices match no channel and are dropped.
        assign w_load[c] = bus.seed_valid && (32'(bus.seed_chan) == c);

        lfsr_channel #(
            .WIDTH (WIDTH),
            .STEPS (STEPS),
            .INIT  (c + 1)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_load     (w_load[c]),
            .i_seed     (bus.seed),
            .i_adv      (w_fire),
            .o_state    (w_rnd[c*WIDTH +: WIDTH]),
            .o_zero_fix (w_zero_fix[c])
        );
    end

    // stop dominates start; start in RUN and stop in IDLE fall through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= IDLE;
            r_rnd_valid  <= 1'b0;
            r_xfer_count <= 32'd0;
        end else begin
            if (w_fire) begin
                r_xfer_count <= r_xfer_count + 32'd1;
            end
            case (r_fsm)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_fsm       <= RUN;
                        r_rnd_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        r_fsm       <= IDLE;
                        r_rnd_valid <= 1'b0;
                    end
                end
                default: begin
                    r_fsm       <= IDLE;
                    r_rnd_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.seed_ready    = 1'b1;
    assign bus.seed_zero_fix = |w_zero_fix;
    assign bus.rnd_valid     = r_rnd_valid;
    assign bus.rnd           = w_rnd;
    assign bus.xfer_count    = r_xfer_count;
endmodule

// File: tb/tb_lfsr_bank.sv
// Bench for lfsr_bank: 4-bit/4-channel/1-step instance against a cycle-position model,
// plus a 4-bit/3-channel/2-step instance for leap-ahead and out-of-range seeds.
module tb_lfsr_bank;

    logic clk;
    logic rst_a;
    logic rst_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lfsr_bank_if #(.WIDTH(4), .CHANNELS(4)) bus_a ();
    lfsr_bank_if #(.WIDTH(4), .CHANNELS(3)) bus_b ();

    lfsr_bank #(.WIDTH(4), .CHANNELS(4), .STEPS(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    lfsr_bank #(.WIDTH(4), .CHANNELS(3), .STEPS(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    // The full period of x^4+x^3+1 starting at 1; advancing k shifts = moving k places.
    int SEQ [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
    int LEAP [4] = '{4, 3, 13, 5};

    int          n_total;
    int          n_pass;
    int          m_st [4];
    bit          m_run;
    logic [31:0] m_cnt;
    bit          m_zf;

    function automatic int adv(input int s, input int k);
        int p;
        p = 0;
        for (int i = 0; i < 15; i++) begin
            if (SEQ[i] == s) p = i;
        end
        return SEQ[(p + k) % 15];
    endfunction

    function automatic logic [15:0] m_pack();
        logic [15:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[c*4 +: 4] = 4'(m_st[c]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick_a(input string tag);
        bit fire;
        @(posedge clk);
        fire = m_run && (bus_a.rnd_ready === 1'b1);
        if (rst_a) begin
            m_run = 1'b0;
            m_cnt = 32'd0;
            m_zf  = 1'b0;
            for (int c = 0; c < 4; c++) m_st[c] = c + 1;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (bus_a.seed_valid && int'(bus_a.seed_chan) == c)
                    m_st[c] = (bus_a.seed == 4'd0) ? 1 : int'(bus_a.seed);
                else if (fire)
                    m_st[c] = adv(m_st[c], 1);
            end
            m_zf = bus_a.seed_valid && (bus_a.seed == 4'd0);
            if (fire) m_cnt = m_cnt + 32'd1;
            if (m_run) begin
                if (bus_a.stop) m_run = 1'b0;
            end else if (bus_a.start && !bus_a.stop) begin
                m_run = 1'b1;
            end
        end
        #1;
        chk({tag, "_vld"}, 64'(bus_a.rnd_valid), 64'(m_run));
        chk({tag, "_rnd"}, 64'(bus_a.rnd), 64'(m_pack()));
        chk({tag, "_cnt"}, 64'(bus_a.xfer_count), 64'(m_cnt));
        chk({tag, "_zf"}, 64'(bus_a.seed_zero_fix), 64'(m_zf));
        bus_a.start      = 1'b0;
        bus_a.stop       = 1'b0;
        bus_a.seed_valid = 1'b0;
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
        bus_b.start      = 1'b0;
        bus_b.stop       = 1'b0;
        bus_b.seed_valid = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        m_run   = 1'b0;
        m_cnt   = 32'd0;
        m_zf    = 1'b0;
        for (int c = 0; c < 4; c++) m_st[c] = c + 1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.seed_valid = 1'b0;
        bus_a.seed_chan = '0; bus_a.seed = '0; bus_a.rnd_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.seed_valid = 1'b0;
        bus_b.seed_chan = '0; bus_b.seed = '0; bus_b.rnd_ready = 1'b0;

        // Reset state
        tick_a("rst0");
        chk("rst_seed_rdy", 64'(bus_a.seed_ready), 64'd1);
        tick_a("rst1");
        chk("rst_rnd", 64'(bus_a.rnd), 64'h4321);
        chk("rst_cnt", 64'(bus_a.xfer_count), 64'd0);
        rst_a = 1'b0;
        chk("post_rst_seed_rdy", 64'(bus_a.seed_ready), 64'd1);

        // Seed ch0 with 1, start, and walk the whole period
        bus_a.seed_valid = 1'b1; bus_a.seed_chan = 2'd0; bus_a.seed = 4'h1;
        tick_a("seed0");
        bus_a.start = 1'b1; bus_a.rnd_ready = 1'b1;
        tick_a("start");
        chk("start_vld", 64'(bus_a.rnd_valid), 64'd1);
        for (int i = 0; i < 15; i++) begin
            tick_a("seq");
            chk("seq_ch0", 64'(bus_a.rnd[3:0]), 64'(SEQ[(i + 1) % 15]));
        end
        chk("period_ch0", 64'(bus_a.rnd[3:0]), 64'd1);
        chk("period_cnt", 64'(bus_a.xfer_count), 64'd15);

        // Backpressure
        bus_a.rnd_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick_a("bp_hold");
        chk("bp_cnt", 64'(bus_a.xfer_count), 64'd15);
        chk("bp_ch0", 64'(bus_a.rnd[3:0]), 64'd1);
        bus_a.rnd_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick_a("bp_go");
        chk("bp_go_cnt", 64'(bus_a.xfer_count), 64'd18);
        chk("bp_go_ch0", 64'(bus_a.rnd[3:0]), 64'h9);

        // Zero seed fix-up
        bus_a.rnd_ready = 1'b0;
        bus_a.seed_valid = 1'b1; bus_a.seed_chan = 2'd2; bus_a.seed = 4'h0;
        tick_a("zseed");
        chk("zseed_ch2", 64'(bus_a.rnd[11:8]), 64'd1);
        chk("zseed_pulse", 64'(bus_a.seed_zero_fix), 64'd1);
        tick_a("zseed_after");
        chk("zseed_pulse_end", 64'(bus_a.seed_zero_fix), 64'd0);

        // Seed collides with a transfer
        bus_a.rnd_ready = 1'b1;
        bus_a.seed_valid = 1'b1; bus_a.seed_chan = 2'd1; bus_a.seed = 4'h9;
        tick_a("coll");
        chk("coll_ch1", 64'(bus_a.rnd[7:4]), 64'h9);
        chk("coll_ch0", 64'(bus_a.rnd[3:0]), 64'h3);
        chk("coll_ch2", 64'(bus_a.rnd[11:8]), 64'h2);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bus_a.rnd_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                bus_a.seed_valid = 1'b1;
                bus_a.seed_chan  = 2'($urandom_range(0, 3));
                bus_a.seed       = 4'($urandom_range(0, 15));
            end
            bus_a.start = ($urandom_range(0, 15) == 0);
            bus_a.stop  = ($urandom_range(0, 15) == 0);
            tick_a("rand");
        end

        // start+stop together from RUN
        bus_a.start = 1'b1;
        tick_a("to_run");
        chk("to_run_vld", 64'(bus_a.rnd_valid), 64'd1);
        bus_a.start = 1'b1; bus_a.stop = 1'b1;
        tick_a("ss");
        chk("ss_vld", 64'(bus_a.rnd_valid), 64'd0);

        // Reset in the middle of a transfer
        bus_a.start = 1'b1; bus_a.rnd_ready = 1'b1;
        tick_a("mid_start");
        tick_a("mid_xfer");
        rst_a = 1'b1;
        tick_a("mid_rst");
        chk("mid_rst_rnd", 64'(bus_a.rnd), 64'h4321);
        chk("mid_rst_vld", 64'(bus_a.rnd_valid), 64'd0);
        chk("mid_rst_cnt", 64'(bus_a.xfer_count), 64'd0);
        rst_a = 1'b0;

        // Leap-ahead instance (STEPS=2, CHANNELS=3)
        rst_b = 1'b0;
        bus_b.seed_valid = 1'b1; bus_b.seed_chan = 2'd0; bus_b.seed = 4'h1;
        tick_b();
        chk("b_seed_rnd", 64'(bus_b.rnd), 64'h321);
        chk("b_idle_vld", 64'(bus_b.rnd_valid), 64'd0);
        bus_b.start = 1'b1; bus_b.rnd_ready = 1'b1;
        tick_b();
        chk("b_start_vld", 64'(bus_b.rnd_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick_b();
            chk("b_leap_ch0", 64'(bus_b.rnd[3:0]), 64'(LEAP[i]));
        end
        chk("b_leap_cnt", 64'(bus_b.xfer_count), 64'd4);

        // Out-of-range channel index is ignored, including a zero seed
        bus_b.rnd_ready = 1'b0;
        bus_b.seed_valid = 1'b1; bus_b.seed_chan = 2'd3; bus_b.seed = 4'h7;
        tick_b();
        chk("b_oob_rnd", 64'(bus_b.rnd), 64'hEB5);
        bus_b.seed_valid = 1'b1; bus_b.seed_chan = 2'd3; bus_b.seed = 4'h0;
        tick_b();
        chk("b_oob_zf", 64'(bus_b.seed_zero_fix), 64'd0);
        chk("b_oob_rnd2", 64'(bus_b.rnd), 64'hEB5);
        chk("b_oob_cnt", 64'(bus_b.xfer_count), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
